// File: rtl/washer_pkg.sv
// Shared types for the washer sequencer: state codes, mode codes and helpers.
package washer_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_FILL    = 4'd1,
        ST_AGIT_F  = 4'd2,
        ST_PAUSE_A = 4'd3,
        ST_AGIT_R  = 4'd4,
        ST_PAUSE_B = 4'd5,
        ST_DRAIN   = 4'd6,
        ST_SPIN    = 4'd7,
        ST_DONE    = 4'd8
    } state_e;

    typedef enum logic [1:0] {
        MODE_FULL  = 2'b00,   // wash + RINSE_MAX rinses + spin
        MODE_SHORT = 2'b01,   // wash + 1 rinse + spin
        MODE_RINSE = 2'b10,   // RINSE_MAX rinses + spin
        MODE_SPIN  = 2'b11    // drain + spin only
    } mode_e;

    // Total number of fill/agitate/drain passes a mode runs.
    function automatic int unsigned pass_count(input logic [1:0] m, input int unsigned rinse_max);
        case (m)
            2'b00:   return rinse_max + 1;
            2'b01:   return 2;
            2'b10:   return rinse_max;
            default: return 0;
        endcase
    endfunction

    function automatic logic is_busy(input state_e s);
        return !(s == ST_IDLE || s == ST_DONE);
    endfunction

endpackage

// File: rtl/washer_phase_timer.sv
// Down-counting phase timer: loaded with (duration-1) on state entry,
// done while the count is zero, ticks only when enabled.
module washer_phase_timer #(
    parameter int TICK_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [TICK_W-1:0] load_val_i,
    input  logic              tick_i,
    output logic              done_o
);

    logic [TICK_W-1:0] tmr_q;

    // Reload takes priority; otherwise count down to zero and stop there.
    always_ff @(posedge clk) begin
        if (rst)
            tmr_q <= '0;
        else if (load_i)
            tmr_q <= load_val_i;
        else if (tick_i && tmr_q != '0)
            tmr_q <= tmr_q - 1'b1;
    end

    assign done_o = (tmr_q == '0);

endmodule

// File: rtl/washer_seq_ctrl.sv
// Washing-machine program sequencer: wash pass, rinse passes, final spin.
// Optional build macro WASHER_PAUSE_EN: EN=0 while busy pauses the program
// (actuators off, everything else frozen) instead of aborting to IDLE.
module washer_seq_ctrl
    import washer_pkg::*;
#(
    parameter int TICK_W    = 4,
    parameter int T_FILL    = 2,
    parameter int T_AGIT    = 3,
    parameter int T_IDLE    = 1,
    parameter int T_DRAIN   = 2,
    parameter int T_SPIN    = 3,
    parameter int AGIT_CYC  = 3,
    parameter int RINSE_MAX = 2,
    parameter int CNT_W     = 10
) (
    input  logic             cp,
    input  logic             R,
    input  logic             EN,
    input  logic             start,
    input  logic [1:0]       mode,
    output logic             JS,
    output logic             PS,
    output logic             ZZ,
    output logic             FZ,
    output logic             QX,
    output logic             PX,
    output logic             TS,
    output logic             BJ,
    output logic             busy,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] count
);

    localparam int PW = $clog2(RINSE_MAX + 2);
    localparam int AW = $clog2(AGIT_CYC + 1);
    localparam logic [AW-1:0] AGIT_LAST = AW'(AGIT_CYC - 1);

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d;
    logic [PW-1:0]     pass_q, pass_d;     // passes still to run after the current one
    logic [AW-1:0]     agit_q, agit_d;     // completed fwd/rev cycles in this pass
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              js_q, ps_q, zz_q, fz_q, qx_q, px_q, ts_q, bj_q, busy_q;
    logic              js_d, ps_d, zz_d, fz_d, qx_d, px_d, ts_d, bj_d, busy_d;
    logic              paused;
    logic              tmr_done;

    // Timer reload value for the state being entered (duration minus one).
    function automatic logic [TICK_W-1:0] dur(input state_e s);
        case (s)
            ST_FILL:               return TICK_W'(T_FILL - 1);
            ST_AGIT_F, ST_AGIT_R:  return TICK_W'(T_AGIT - 1);
            ST_PAUSE_A, ST_PAUSE_B: return TICK_W'(T_IDLE - 1);
            ST_DRAIN:              return TICK_W'(T_DRAIN - 1);
            ST_SPIN:               return TICK_W'(T_SPIN - 1);
            default:               return '0;
        endcase
    endfunction

    washer_phase_timer #(.TICK_W(TICK_W)) u_timer (
        .clk        (cp),
        .rst        (R),
        .load_i     (state_d != state_q),
        .load_val_i (dur(state_d)),
        .tick_i     (EN),
        .done_o     (tmr_done)
    );

    // State, counters and registered outputs.
    always_ff @(posedge cp) begin
        if (R) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_FULL;
            pass_q  <= '0;
            agit_q  <= '0;
            cnt_q   <= '0;
            js_q <= 1'b0; ps_q <= 1'b0; zz_q <= 1'b0; fz_q <= 1'b0;
            qx_q <= 1'b0; px_q <= 1'b0; ts_q <= 1'b0; bj_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            pass_q  <= pass_d;
            agit_q  <= agit_d;
            cnt_q   <= cnt_d;
            js_q <= js_d; ps_q <= ps_d; zz_q <= zz_d; fz_q <= fz_d;
            qx_q <= qx_d; px_q <= px_d; ts_q <= ts_d; bj_q <= bj_d;
            busy_q <= busy_d;
        end
    end

    // Next-state, counters and output decode from the next state.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        pass_d  = pass_q;
        agit_d  = agit_q;
        cnt_d   = cnt_q;
        qx_d    = qx_q;
        px_d    = px_q;
        paused  = 1'b0;

        if (!is_busy(state_q)) begin
            if (EN && start) begin
                mode_d = mode_e'(mode);
                cnt_d  = '0;
                agit_d = '0;
                qx_d   = (mode == MODE_FULL) || (mode == MODE_SHORT);
                px_d   = (mode == MODE_RINSE);
                if (mode == MODE_SPIN) begin
                    state_d = ST_DRAIN;
                    pass_d  = '0;
                end else begin
                    state_d = ST_FILL;
                    pass_d  = PW'(pass_count(mode, RINSE_MAX) - 1);
                end
            end
        end else if (!EN) begin
`ifdef WASHER_PAUSE_EN
            paused = 1'b1;
`else
            state_d = ST_IDLE;
            pass_d  = '0;
            agit_d  = '0;
            cnt_d   = '0;
            qx_d    = 1'b0;
            px_d    = 1'b0;
`endif
        end else begin
            if (cnt_q != '1)
                cnt_d = cnt_q + 1'b1;
            if (tmr_done) begin
                case (state_q)
                    ST_FILL:    begin state_d = ST_AGIT_F; agit_d = '0; end
                    ST_AGIT_F:  state_d = ST_PAUSE_A;
                    ST_PAUSE_A: state_d = ST_AGIT_R;
                    ST_AGIT_R:  state_d = ST_PAUSE_B;
                    ST_PAUSE_B: begin
                        if (agit_q != AGIT_LAST) begin
                            state_d = ST_AGIT_F;
                            agit_d  = agit_q + 1'b1;
                        end else begin
                            state_d = ST_DRAIN;
                            agit_d  = '0;
                        end
                    end
                    ST_DRAIN: begin
                        // Drain-only programs never refill, whatever pass_q says.
                        if (pass_q != '0 && mode_q != MODE_SPIN) begin
                            state_d = ST_FILL;
                            pass_d  = pass_q - 1'b1;
                            qx_d    = 1'b0;
                            px_d    = 1'b1;
                        end else begin
                            state_d = ST_SPIN;
                        end
                    end
                    ST_SPIN: begin
                        state_d = ST_DONE;
                        qx_d    = 1'b0;
                        px_d    = 1'b0;
                    end
                    default: ;
                endcase
            end
        end

        js_d   = (state_d == ST_FILL);
        ps_d   = (state_d == ST_DRAIN) || (state_d == ST_SPIN);
        zz_d   = (state_d == ST_AGIT_F) || (state_d == ST_SPIN);
        fz_d   = (state_d == ST_AGIT_R);
        ts_d   = (state_d == ST_SPIN);
        bj_d   = (state_d == ST_DONE);
        busy_d = is_busy(state_d);
        if (paused) begin
            js_d = 1'b0; ps_d = 1'b0; zz_d = 1'b0; fz_d = 1'b0; ts_d = 1'b0;
        end
    end

    assign JS      = js_q;
    assign PS      = ps_q;
    assign ZZ      = zz_q;
    assign FZ      = fz_q;
    assign QX      = qx_q;
    assign PX      = px_q;
    assign TS      = ts_q;
    assign BJ      = bj_q;
    assign busy    = busy_q;
    assign state_o = state_q;
    assign count   = cnt_q;

endmodule

// File: tb/tb_washer_seq_ctrl.sv
// Directed bench for washer_seq_ctrl (default parameters) plus a CNT_W=4
// copy sharing the same stimulus to observe count saturation.
module tb_washer_seq_ctrl;

    logic       cp = 1'b0;
    logic       R, EN, start;
    logic [1:0] mode;
    logic       JS, PS, ZZ, FZ, QX, PX, TS, BJ, busy;
    logic [3:0] state_o;
    logic [9:0] count;
    logic       s_js, s_ps, s_zz, s_fz, s_qx, s_px, s_ts, s_bj, s_busy;
    logic [3:0] s_state;
    logic [3:0] s_count;

    int n_chk = 0;
    int n_fail = 0;
    int edges = 0;
    int cyc, qx_n, px_n, fwd_n, rev_n, ovl_n;
    int e0, c0, guard;

    washer_seq_ctrl u_dut (
        .cp(cp), .R(R), .EN(EN), .start(start), .mode(mode),
        .JS(JS), .PS(PS), .ZZ(ZZ), .FZ(FZ), .QX(QX), .PX(PX), .TS(TS), .BJ(BJ),
        .busy(busy), .state_o(state_o), .count(count)
    );

    washer_seq_ctrl #(.CNT_W(4)) u_sat (
        .cp(cp), .R(R), .EN(EN), .start(start), .mode(mode),
        .JS(s_js), .PS(s_ps), .ZZ(s_zz), .FZ(s_fz), .QX(s_qx), .PX(s_px), .TS(s_ts), .BJ(s_bj),
        .busy(s_busy), .state_o(s_state), .count(s_count)
    );

    always #5 cp = ~cp;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges; inputs change and outputs are sampled 1ns after the edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge cp);
            edges++;
        end
        #1;
    endtask

    function automatic logic [8:0] outs();
        return {JS, PS, ZZ, FZ, QX, PX, TS, BJ, busy};
    endfunction

    // Start a program and run to DONE, tallying lamps, strokes and actuator overlaps.
    // With disturb set, start is pulsed and mode inverted mid-run.
    task automatic run_prog(input logic [1:0] m, input bit disturb);
        logic [3:0] prev;
        cyc = 0; qx_n = 0; px_n = 0; fwd_n = 0; rev_n = 0; ovl_n = 0;
        prev = 4'hF;
        mode = m; start = 1'b1;
        step(1);
        start = 1'b0;
        while (state_o != 4'd8 && cyc < 300) begin
            if (QX) qx_n++;
            if (PX) px_n++;
            if (state_o == 4'd2 && prev != 4'd2) fwd_n++;
            if (state_o == 4'd4 && prev != 4'd4) rev_n++;
            if ((JS && ZZ) || (JS && FZ) || (ZZ && FZ)) ovl_n++;
            if (disturb && cyc == 10) begin start = 1'b1; mode = ~m; end
            if (disturb && cyc == 11) start = 1'b0;
            prev = state_o;
            step(1);
            cyc++;
        end
        mode = m;
    endtask

    initial begin
        R = 1'b1; EN = 1'b0; start = 1'b0; mode = 2'b00;
        step(3);
        chk("reset_state", state_o, 0);
        chk("reset_outs", outs(), 0);
        chk("reset_count", count, 0);

        // Reset wins over a simultaneous start.
        EN = 1'b1; start = 1'b1; mode = 2'b01;
        step(1);
        chk("r_with_start_state", state_o, 0);
        chk("r_with_start_outs", outs(), 0);
        R = 1'b0; start = 1'b0;
        step(1);
        chk("idle_hold", state_o, 0);

        // Drain + spin program.
        mode = 2'b11; start = 1'b1;
        step(1);
        start = 1'b0;
        chk("m11_drain_state", state_o, 6);
        chk("m11_drain_outs", outs(), 9'b010000001);
        step(2);
        chk("m11_spin_outs", outs(), 9'b011000101);
        chk("m11_spin_count", count, 2);
        step(2);
        chk("m11_bj_not_yet", BJ, 0);
        step(1);
        chk("m11_done_state", state_o, 8);
        chk("m11_done_outs", outs(), 9'b000000010);
        chk("m11_count", count, 5);
        step(2);
        chk("m11_done_hold", BJ, 1);

        // Wash + one rinse.
        run_prog(2'b01, 1'b0);
        chk("m01_cycles", cyc, 59);
        chk("m01_qx_cycles", qx_n, 28);
        chk("m01_px_cycles", px_n, 31);
        chk("m01_fwd_strokes", fwd_n, 6);
        chk("m01_rev_strokes", rev_n, 6);
        chk("m01_overlap", ovl_n, 0);
        chk("m01_count", count, 59);
        chk("m01_done_outs", outs(), 9'b000000010);
        chk("sat_count", s_count, 15);
        chk("sat_state", s_state, 8);

        // Full program: wash + two rinses.
        run_prog(2'b00, 1'b0);
        chk("m00_cycles", cyc, 87);
        chk("m00_qx_cycles", qx_n, 28);
        chk("m00_px_cycles", px_n, 59);
        chk("m00_fwd_strokes", fwd_n, 9);
        chk("m00_overlap", ovl_n, 0);
        chk("m00_count", count, 87);

        // Rinse only, with start pulse and mode change while busy.
        run_prog(2'b10, 1'b1);
        chk("m10_cycles", cyc, 59);
        chk("m10_qx_cycles", qx_n, 0);
        chk("m10_px_cycles", px_n, 59);
        chk("m10_rev_strokes", rev_n, 6);
        chk("m10_count", count, 59);

        // EN dropped for 4 cycles in the middle of a reverse stroke.
        mode = 2'b01; start = 1'b1;
        step(1);
        start = 1'b0;
        e0 = edges;
        guard = 0;
        while (state_o != 4'd4 && guard < 50) begin step(1); guard++; end
        chk("en_reach_agit_r", state_o, 4);
        step(1);
        c0 = count;
        EN = 1'b0;
        step(1);
`ifdef WASHER_PAUSE_EN
        chk("pause_state", state_o, 4);
        chk("pause_outs", outs(), 9'b000010001);
        chk("pause_count", count, c0);
        step(3);
        chk("pause_hold_count", count, c0);
        EN = 1'b1;
        guard = 0;
        while (state_o != 4'd8 && guard < 200) begin step(1); guard++; end
        chk("pause_done_edge", edges - e0, 63);
        chk("pause_done_count", count, 59);
`else
        chk("abort_state", state_o, 0);
        chk("abort_outs", outs(), 0);
        chk("abort_count", count, 0);
        step(3);
        chk("abort_stays_idle", state_o, 0);
        EN = 1'b1;
        step(2);
        chk("abort_no_resume", state_o, 0);
`endif

        // Reset in the middle of spin.
        mode = 2'b11; start = 1'b1;
        step(1);
        start = 1'b0;
        step(2);
        chk("r_spin_reached", state_o, 7);
        R = 1'b1;
        step(1);
        chk("r_spin_state", state_o, 0);
        chk("r_spin_outs", outs(), 0);
        chk("r_spin_count", count, 0);
        R = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
